// File: rtl/line_fill_buffer_if.sv
// Purpose : bundles the fill-request side and the word-wide memory side of the line fill buffer.
// Latency : n/a (signal bundle only).
// Backpressure: memory stalls the fill by withholding Mem_Ack; the request side is held off by LB_Busy.
// Ports   : master = requester/memory model view (drives requests and memory replies),
//           slave  = line fill buffer view (drives status, assembled line and memory requests).
interface line_fill_buffer_if #(
    parameter int LINE_WORDS = 8,
    parameter int WORD_W     = 32,
    parameter int ADDR_W     = 32
) ();
    // cache controller side
    logic                         LB_Enable;
    logic [ADDR_W-1:0]            Address;
    logic                         RWordSelect;
    logic                         LB_Busy;
    logic                         LB_FirstWord;
    logic                         LB_Completed;
    logic [LINE_WORDS*WORD_W-1:0] LB_LineData;
    logic [ADDR_W-1:0]            LB_LineAddr;
    // memory side
    logic                         Mem_Req;
    logic [ADDR_W-1:0]            Mem_Addr;
    logic                         Mem_Ack;
    logic [WORD_W-1:0]            Mem_RData;

    modport master (
        output LB_Enable, Address, RWordSelect, Mem_Ack, Mem_RData,
        input  LB_Busy, LB_FirstWord, LB_Completed, LB_LineData, LB_LineAddr,
               Mem_Req, Mem_Addr
    );

    modport slave (
        input  LB_Enable, Address, RWordSelect, Mem_Ack, Mem_RData,
        output LB_Busy, LB_FirstWord, LB_Completed, LB_LineData, LB_LineAddr,
               Mem_Req, Mem_Addr
    );
endinterface

// File: rtl/line_fill_buffer.sv
// Purpose : miss-refill engine; fetches one cache line word by word (critical word first or linear)
//           and presents the assembled line plus its base address.
// Latency : zero-wait memory -> FirstWord one cycle after the critical ack, Completed 9 cycles after accept.
// Backpressure: memory stalls by holding Mem_Ack low (Mem_Addr stays put); new requests are ignored while busy.
// Ports   : Clk, Rst (async, active-high); lb = slave view of line_fill_buffer_if.
module line_fill_buffer #(
    parameter int LINE_WORDS = 8,
    parameter int WORD_W     = 32,
    parameter int ADDR_W     = 32
) (
    input  logic               Clk,
    input  logic               Rst,
    line_fill_buffer_if.slave  lb
);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam logic [IDX_W:0] CNT_LAST = (IDX_W+1)'(LINE_WORDS-1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [WORD_W-1:0]        r_words [LINE_WORDS];
    logic [ADDR_W-1:0]        r_line_addr;
    logic [IDX_W-1:0]         r_idx;
    logic [IDX_W-1:0]         r_crit;
    logic [IDX_W:0]           r_cnt;
    logic                     r_first;
    logic                     w_accept;
    logic                     w_ack;
    logic                     w_last;
    logic [LINE_WORDS*WORD_W-1:0] w_line;

    // Acks are only meaningful while a request is outstanding.
    assign w_accept = (r_state == S_IDLE) && lb.LB_Enable;
    assign w_ack    = (r_state == S_FETCH) && lb.Mem_Ack;
    assign w_last   = w_ack && (r_cnt == CNT_LAST);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (lb.LB_Enable) w_state_nxt = S_FETCH;
            S_FETCH: if (w_last)       w_state_nxt = S_DONE;
            S_DONE:                    w_state_nxt = S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                r_words[i] <= '0;
            end
            r_line_addr <= '0;
            r_idx       <= '0;
            r_crit      <= '0;
            r_cnt       <= '0;
            r_first     <= 1'b0;
        end else begin
            r_first <= 1'b0;
            if (w_accept) begin
                // Line storage is deliberately left alone; the new fill overwrites it slot by slot.
                r_line_addr <= {lb.Address[ADDR_W-1:IDX_W], {IDX_W{1'b0}}};
                r_idx       <= lb.RWordSelect ? lb.Address[IDX_W-1:0] : '0;
                r_crit      <= lb.Address[IDX_W-1:0];
                r_cnt       <= '0;
            end else if (w_ack) begin
                r_words[r_idx] <= lb.Mem_RData;
                r_idx          <= r_idx + 1'b1;   // power-of-two line: natural wrap
                r_cnt          <= r_cnt + 1'b1;
                if (r_idx == r_crit) begin
                    r_first <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_line = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            w_line[i*WORD_W +: WORD_W] = r_words[i];
        end
    end

    // Request/status decode straight from state so reset removes them without waiting for a clock.
    assign lb.Mem_Req      = (r_state == S_FETCH);
    assign lb.Mem_Addr     = {r_line_addr[ADDR_W-1:IDX_W], r_idx};
    assign lb.LB_Busy      = (r_state != S_IDLE);
    assign lb.LB_Completed = (r_state == S_DONE);
    assign lb.LB_FirstWord = r_first;
    assign lb.LB_LineData  = w_line;
    assign lb.LB_LineAddr  = r_line_addr;
endmodule

// File: tb/tb_line_fill_buffer.sv
// Purpose : self-checking bench for line_fill_buffer: directed vector table, hand sequences and random fills.
// Latency : n/a.
// Backpressure: the bench's memory model inserts random 0..N cycle ack stalls.
module tb_line_fill_buffer;
    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [31:0] mem_salt;

    line_fill_buffer_if #(.LINE_WORDS(8), .WORD_W(32), .ADDR_W(32)) lb ();

    line_fill_buffer #(.LINE_WORDS(8), .WORD_W(32), .ADDR_W(32)) dut (
        .Clk (clk),
        .Rst (rst),
        .lb  (lb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        rws;
        int          stall_max;
        int          first_exp;   // ack number (1-based) that delivers the critical word
        logic [31:0] laddr;
    } vec_t;

    vec_t vecs [6];

    // Memory contents: salt 0 gives the simple 0xA0+slot pattern.
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (mem_salt == 32'd0) return 32'hA0 + {29'd0, a[2:0]};
        return (a * 32'h9E37_79B1) ^ mem_salt;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Runs one fill from the current negedge and checks it end to end.
    task automatic do_fill(input logic [31:0] addr, input logic rws, input int stall_max,
                           input int first_exp, input logic [31:0] laddr_exp, input logic hold);
        int acks, n_first, n_comp, first_at, first_cyc, comp_cyc, stall;
        logic [2:0]  start;
        logic [2:0]  slot;
        logic [31:0] base;
        base  = {addr[31:3], 3'b000};
        start = rws ? addr[2:0] : 3'd0;
        lb.LB_Enable   = 1'b1;
        lb.Address     = addr;
        lb.RWordSelect = rws;
        lb.Mem_Ack     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (!hold) lb.LB_Enable = 1'b0;
        chk("busy_after_accept", {255'd0, lb.LB_Busy}, 256'd1);
        acks = 0; n_first = 0; n_comp = 0; first_at = -1; first_cyc = -1; comp_cyc = -1;
        stall = $urandom_range(stall_max, 0);
        for (int cyc = 0; cyc < 200 && n_comp == 0; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (lb.LB_FirstWord) begin
                n_first++; first_at = acks; first_cyc = cyc;
            end
            if (lb.LB_Completed) begin
                n_comp++; comp_cyc = cyc;
                chk("acks_at_completed", 256'(acks), 256'd8);
                chk("busy_in_done", {255'd0, lb.LB_Busy}, 256'd1);
                chk("memreq_in_done", {255'd0, lb.Mem_Req}, 256'd0);
            end
            lb.Mem_Ack   = 1'b0;
            lb.Mem_RData = $urandom;
            if (lb.Mem_Req) begin
                if (acks < 8) begin
                    slot = start + acks[2:0];
                    chk("mem_addr", 256'(lb.Mem_Addr), 256'(base | {29'd0, slot}));
                end else begin
                    chk("mem_req_after_last", {255'd0, lb.Mem_Req}, 256'd0);
                end
                if (stall == 0) begin
                    lb.Mem_Ack   = 1'b1;
                    lb.Mem_RData = memf(lb.Mem_Addr);
                    acks++;
                    stall = $urandom_range(stall_max, 0);
                end else begin
                    stall--;
                end
            end
        end
        lb.Mem_Ack = 1'b0;
        @(negedge clk);
        chk("busy_after_done", {255'd0, lb.LB_Busy}, 256'd0);
        chk("completed_one_cycle", {255'd0, lb.LB_Completed}, 256'd0);
        chk("firstword_cleared", {255'd0, lb.LB_FirstWord}, 256'd0);
        chk("firstword_count", 256'(n_first), 256'd1);
        chk("firstword_ack", 256'(first_at), 256'(first_exp));
        chk("completed_count", 256'(n_comp), 256'd1);
        chk("line_addr", 256'(lb.LB_LineAddr), 256'(laddr_exp));
        for (int i = 0; i < 8; i++) begin
            chk("line_word", 256'(lb.LB_LineData[i*32 +: 32]), 256'(memf(base | 32'(i))));
        end
        if (stall_max == 0) begin
            chk("completed_latency", 256'(comp_cyc), 256'd8);
            chk("firstword_latency", 256'(first_cyc), 256'(first_exp));
        end
    endtask

    initial begin
        logic [255:0] saved;
        logic [31:0]  a;
        logic         r;
        int           fe, nf, nc, nb;
        errors = 0; checks = 0; mem_salt = 32'd0;

        //          addr          rws  stall first laddr
        vecs[0] = '{32'h0000_1235, 1'b1, 0, 1, 32'h0000_1230};
        vecs[1] = '{32'h0000_1235, 1'b0, 0, 6, 32'h0000_1230};
        vecs[2] = '{32'h0000_0047, 1'b1, 0, 1, 32'h0000_0040};
        vecs[3] = '{32'h0000_0040, 1'b0, 0, 1, 32'h0000_0040};
        vecs[4] = '{32'h0000_1235, 1'b1, 3, 1, 32'h0000_1230};
        vecs[5] = '{32'h0000_0047, 1'b0, 3, 8, 32'h0000_0040};

        rst = 1'b1;
        lb.LB_Enable = 1'b0; lb.Address = '0; lb.RWordSelect = 1'b0;
        lb.Mem_Ack = 1'b0; lb.Mem_RData = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {255'd0, lb.LB_Busy}, 256'd0);
        chk("rst_memreq", {255'd0, lb.Mem_Req}, 256'd0);
        chk("rst_first", {255'd0, lb.LB_FirstWord}, 256'd0);
        chk("rst_completed", {255'd0, lb.LB_Completed}, 256'd0);
        chk("rst_linedata", lb.LB_LineData, 256'd0);
        chk("rst_lineaddr", 256'(lb.LB_LineAddr), 256'd0);
        chk("rst_memaddr", 256'(lb.Mem_Addr), 256'd0);

        for (int v = 0; v < 6; v++) begin
            do_fill(vecs[v].addr, vecs[v].rws, vecs[v].stall_max, vecs[v].first_exp, vecs[v].laddr, 1'b0);
        end
        chk("word0_pattern", 256'(lb.LB_LineData[31:0]), 256'h0A0);
        chk("word7_pattern", 256'(lb.LB_LineData[255:224]), 256'h0A7);

        // Acks while idle must not disturb anything.
        saved = lb.LB_LineData;
        for (int k = 0; k < 4; k++) begin
            lb.Mem_Ack = 1'b1; lb.Mem_RData = $urandom;
            @(negedge clk);
            chk("idle_ack_busy", {255'd0, lb.LB_Busy}, 256'd0);
        end
        lb.Mem_Ack = 1'b0;
        chk("idle_ack_line", lb.LB_LineData, saved);

        // LB_Enable held throughout: re-accept only after returning to IDLE.
        mem_salt = 32'h1357_9BDF;
        do_fill(32'h0000_3003, 1'b1, 1, 1, 32'h0000_3000, 1'b1);
        chk("hold_line_kept", 256'(lb.LB_LineData[95:64]), 256'(memf(32'h0000_3002)));
        do_fill(32'h0000_5556, 1'b0, 0, 7, 32'h0000_5550, 1'b0);

        // Reset after the third ack aborts the fill.
        lb.LB_Enable = 1'b1; lb.Address = 32'h0000_1237; lb.RWordSelect = 1'b0;
        @(posedge clk);
        @(negedge clk);
        lb.LB_Enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            lb.Mem_Ack = 1'b1; lb.Mem_RData = memf(lb.Mem_Addr);
            @(negedge clk);
        end
        lb.Mem_Ack = 1'b0;
        chk("pre_abort_busy", {255'd0, lb.LB_Busy}, 256'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_memreq", {255'd0, lb.Mem_Req}, 256'd0);
        chk("abort_busy", {255'd0, lb.LB_Busy}, 256'd0);
        chk("abort_line_clear", lb.LB_LineData, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        nf = 0; nc = 0; nb = 0;
        for (int k = 0; k < 12; k++) begin
            lb.Mem_Ack = 1'b1; lb.Mem_RData = $urandom;
            @(negedge clk);
            nf += int'(lb.LB_FirstWord);
            nc += int'(lb.LB_Completed);
            nb += int'(lb.LB_Busy);
        end
        lb.Mem_Ack = 1'b0;
        chk("abort_no_first", 256'(nf), 256'd0);
        chk("abort_no_completed", 256'(nc), 256'd0);
        chk("abort_stays_idle", 256'(nb), 256'd0);
        do_fill(32'h0000_0042, 1'b1, 2, 1, 32'h0000_0040, 1'b0);

        // Random fills checked against arithmetic expectations.
        for (int n = 0; n < 25; n++) begin
            a  = $urandom;
            r  = 1'($urandom_range(1, 0));
            mem_salt = $urandom | 32'd1;
            fe = ((int'(a[2:0]) - (r ? int'(a[2:0]) : 0) + 8) % 8) + 1;
            do_fill(a, r, 3, fe, a & ~32'h7, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
